ads868x_scan_sequencer: RTL

//  Sequences the ADS868x front end: on a trigger it walks the enabled analog channels.
//  Per channel: drive CH_SEL_A/EN_TCH_A/EN_PCH_A, wait a settle time, request one SPI conversion, stream the result.

---
 rtl/ads868x_scan_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ads868x_scan_sequencer.sv
// ads868x_scan_sequencer
// Walks the enabled ADS868x analog channels on each trigger: selects the mux
// channel and T/P path, waits the settle time, requests one SPI conversion and
// streams the result downstream. scan_done marks the end of a scan.
// Optional conversion watchdog: define ADS868X_SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for trig & enable
// NEXT     | one cycle: find lowest enabled channel >= current index
// SETTLE   | mux/path outputs driven, settle counter running
// CONVERT  | conv_req high until conv_done (or watchdog expiry)
// OUTPUT   | m_valid high until accepted
// DONE     | scan_done pulse, back to IDLE
module ads868x_scan_sequencer #(
    parameter int NUM_CH         = 8,
    parameter int SETTLE_CYCLES  = 250,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trig,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] ch_pch,
    output logic [2:0]        ch_sel,
    output logic              en_tch,
    output logic              en_pch,
    output logic              conv_req,
    input  logic              conv_done,
    input  logic [15:0]       conv_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [2:0]        m_ch,
    output logic [15:0]       m_data,
    output logic              busy,
    output logic              scan_done,
    output logic              overrun,
    output logic              timeout
);

    // One counter serves both the settle delay and the conversion watchdog.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_OUTPUT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] pch_q, pch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        ch_sel_q, ch_sel_d;
    logic              en_tch_q, en_tch_d;
    logic              en_pch_q, en_pch_d;
    logic [2:0]        m_ch_q, m_ch_d;
    logic [15:0]       m_data_q, m_data_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              abort_q, abort_d;

    logic              hit;
    logic [3:0]        hit_idx;
    logic              hit_pch;

    // Lowest enabled channel at or above the current index; never wraps.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        hit_pch = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) >= idx_q)) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
                hit_pch = pch_q[i];
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        pch_d     = pch_q;
        cnt_d     = cnt_q;
        ch_sel_d  = ch_sel_q;
        en_tch_d  = en_tch_q;
        en_pch_d  = en_pch_q;
        m_ch_d    = m_ch_q;
        m_data_d  = m_data_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        abort_d   = abort_q;

        // DONE still counts as busy, so a trigger there is an overrun too.
        if (trig && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trig && enable) begin
                    mask_d    = ch_mask;
                    pch_d     = ch_pch;
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                    abort_d   = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    idx_d    = hit_idx;
                    ch_sel_d = hit_idx[2:0];
                    en_pch_d = hit_pch;
                    en_tch_d = ~hit_pch;
                    cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                    state_d  = S_SETTLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SETTLE: begin
                if (!enable) begin
                    en_tch_d = 1'b0;
                    en_pch_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
                    state_d = S_CONVERT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CONVERT: begin
                // An in-flight SPI transfer is never cut; an abort is
                // remembered and honoured once the conversion finishes.
                if (!enable) begin
                    abort_d = 1'b1;
                end
                if (conv_done) begin
                    if (abort_q || !enable) begin
                        en_tch_d = 1'b0;
                        en_pch_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        m_data_d = conv_data;
                        m_ch_d   = idx_q[2:0];
                        state_d  = S_OUTPUT;
                    end
                end
`ifdef ADS868X_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    if (abort_q || !enable) begin
                        en_tch_d = 1'b0;
                        en_pch_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        m_data_d = 16'hFFFF;
                        m_ch_d   = idx_q[2:0];
                        state_d  = S_OUTPUT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_OUTPUT: begin
                if (!enable) begin
                    en_tch_d = 1'b0;
                    en_pch_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (m_ready) begin
                    idx_d    = idx_q + 4'd1;
                    en_tch_d = 1'b0;
                    en_pch_d = 1'b0;
                    state_d  = S_NEXT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            mask_q    <= '0;
            pch_q     <= '0;
            cnt_q     <= '0;
            ch_sel_q  <= 3'd0;
            en_tch_q  <= 1'b0;
            en_pch_q  <= 1'b0;
            m_ch_q    <= 3'd0;
            m_data_q  <= 16'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            pch_q     <= pch_d;
            cnt_q     <= cnt_d;
            ch_sel_q  <= ch_sel_d;
            en_tch_q  <= en_tch_d;
            en_pch_q  <= en_pch_d;
            m_ch_q    <= m_ch_d;
            m_data_q  <= m_data_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    // Status outputs decoded from state; m_valid drops at once on abort.
    always_comb begin
        ch_sel    = ch_sel_q;
        en_tch    = en_tch_q;
        en_pch    = en_pch_q;
        conv_req  = (state_q == S_CONVERT);
        m_valid   = (state_q == S_OUTPUT) && enable;
        m_ch      = m_ch_q;
        m_data    = m_data_q;
        busy      = (state_q != S_IDLE);
        scan_done = (state_q == S_DONE);
        overrun   = overrun_q;
        timeout   = timeout_q;
    end

endmodule
